// File: rtl/pio_pkg.sv
// Shared PIO constants: IRQ controller register addresses and per-output register offsets.
package pio_pkg;

  localparam logic [4:0] PIO_IRQ_ADDR_IRQ        = 5'h00;
  localparam logic [4:0] PIO_IRQ_ADDR_FORCE      = 5'h01;
  localparam logic [4:0] PIO_IRQ_ADDR_INTR       = 5'h02;
  localparam logic [4:0] PIO_IRQ_ADDR_OUT_BASE   = 5'h04;
  localparam logic [4:0] PIO_IRQ_ADDR_OUT_STRIDE = 5'h04;

  localparam logic [1:0] PIO_IRQ_OFF_INTE = 2'd0;
  localparam logic [1:0] PIO_IRQ_OFF_INTF = 2'd1;
  localparam logic [1:0] PIO_IRQ_OFF_INTS = 2'd2;

  // Output index for an address in the per-output window; only meaningful at or above OUT_BASE.
  function automatic logic [2:0] pio_irq_out_index(input logic [4:0] addr);
    logic [4:0] rel;
    rel = (addr - PIO_IRQ_ADDR_OUT_BASE) / PIO_IRQ_ADDR_OUT_STRIDE;
    return rel[2:0];
  endfunction

endpackage

// File: rtl/pio_irq_out.sv
// One interrupt output: INTE/INTF registers, INTS = (raw & inte) | intf, irq = |INTS.
// PIO_IRQ_REG_OUT_EN selects a registered irq; otherwise irq is combinational.
module pio_irq_out #(
  parameter int RAW_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [RAW_W-1:0] raw,
  input  logic             wr_inte,
  input  logic             wr_intf,
  input  logic [RAW_W-1:0] wdata,
  output logic [RAW_W-1:0] inte,
  output logic [RAW_W-1:0] intf,
  output logic [RAW_W-1:0] ints,
  output logic             irq
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inte <= '0;
      intf <= '0;
    end else begin
      if (wr_inte) inte <= wdata;
      if (wr_intf) intf <= wdata;
    end
  end

  assign ints = (raw & inte) | intf;

`ifdef PIO_IRQ_REG_OUT_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |ints;
  end

  assign irq = irq_q;
`else
  assign irq = |ints;
`endif

endmodule

// File: rtl/pio_irq_ctrl.sv
// PIO IRQ flag register, raw interrupt sources, host register port and NUM_IRQ_OUTS outputs.
// Optional macro PIO_IRQ_REG_OUT_EN registers the irq outputs (see pio_irq_out).
module pio_irq_ctrl
  import pio_pkg::*;
#(
  parameter int NUM_MACHINES = 4,
  parameter int NUM_FLAGS    = 8,
  parameter int NUM_EXPORT   = 4,
  parameter int NUM_IRQ_OUTS = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_MACHINES*NUM_FLAGS-1:0] sm_set,
  input  logic [NUM_MACHINES*NUM_FLAGS-1:0] sm_clr,
  input  logic [NUM_MACHINES-1:0]        tx_full,
  input  logic [NUM_MACHINES-1:0]        rx_empty,
  output logic [NUM_FLAGS-1:0]           flags,
  output logic [NUM_FLAGS-1:0]           flags_prev,
  input  logic                           reg_wr,
  input  logic                           reg_rd,
  input  logic [4:0]                     reg_addr,
  input  logic [31:0]                    reg_wdata,
  output logic [31:0]                    reg_rdata,
  output logic                           reg_rvalid,
  output logic [NUM_IRQ_OUTS-1:0]        irq
);

  localparam int         RAW_W = NUM_EXPORT + 2*NUM_MACHINES;
  localparam logic [2:0] NOUT  = 3'(NUM_IRQ_OUTS);

  if (RAW_W > 32) begin : g_raw_w_check
    $error("pio_irq_ctrl: RAW_W = NUM_EXPORT + 2*NUM_MACHINES must not exceed 32");
  end
  if (NUM_EXPORT > NUM_FLAGS) begin : g_export_check
    $error("pio_irq_ctrl: NUM_EXPORT must not exceed NUM_FLAGS");
  end

  logic [NUM_FLAGS-1:0] host_clr, host_force, any_set, any_clr;
  logic [RAW_W-1:0]     raw;
  logic [2:0]           out_idx;
  logic                 out_hit, wr_irq, wr_force;
  logic [31:0]          rd_val;
  logic                 unused_wdata;

  logic [RAW_W-1:0] inte_a [NUM_IRQ_OUTS];
  logic [RAW_W-1:0] intf_a [NUM_IRQ_OUTS];
  logic [RAW_W-1:0] ints_a [NUM_IRQ_OUTS];

  always_comb begin
    any_set = host_force;
    any_clr = host_clr;
    for (int m = 0; m < NUM_MACHINES; m++) begin
      any_set = any_set | sm_set[m*NUM_FLAGS +: NUM_FLAGS];
      any_clr = any_clr | sm_clr[m*NUM_FLAGS +: NUM_FLAGS];
    end
  end

  assign raw          = {flags[NUM_EXPORT-1:0], tx_full, rx_empty};
  assign wr_irq       = reg_wr && (reg_addr == PIO_IRQ_ADDR_IRQ);
  assign wr_force     = reg_wr && (reg_addr == PIO_IRQ_ADDR_FORCE);
  assign out_idx      = pio_irq_out_index(reg_addr);
  assign out_hit      = (reg_addr >= PIO_IRQ_ADDR_OUT_BASE) && (out_idx < NOUT);
  assign unused_wdata = ^reg_wdata;

  // Set only acts on a clear flag and clear only on a set flag, so set+clear toggles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags      <= '0;
      flags_prev <= '0;
      host_clr   <= '0;
      host_force <= '0;
    end else begin
      flags      <= (~flags & any_set) | (flags & ~any_clr);
      flags_prev <= flags;
      host_clr   <= wr_irq   ? reg_wdata[NUM_FLAGS-1:0] : '0;
      host_force <= wr_force ? reg_wdata[NUM_FLAGS-1:0] : '0;
    end
  end

  for (genvar k = 0; k < NUM_IRQ_OUTS; k++) begin : g_out
    logic hit_k;
    assign hit_k = reg_wr && out_hit && (out_idx == 3'(k));

    pio_irq_out #(.RAW_W(RAW_W)) u_out (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw),
      .wr_inte (hit_k && (reg_addr[1:0] == PIO_IRQ_OFF_INTE)),
      .wr_intf (hit_k && (reg_addr[1:0] == PIO_IRQ_OFF_INTF)),
      .wdata   (reg_wdata[RAW_W-1:0]),
      .inte    (inte_a[k]),
      .intf    (intf_a[k]),
      .ints    (ints_a[k]),
      .irq     (irq[k])
    );
  end

  // Read mux samples register state before any same-cycle write lands.
  always_comb begin
    rd_val = '0;
    if (reg_addr == PIO_IRQ_ADDR_IRQ) begin
      rd_val[NUM_FLAGS-1:0] = flags;
    end else if (reg_addr == PIO_IRQ_ADDR_INTR) begin
      rd_val[RAW_W-1:0] = raw;
    end else if (out_hit) begin
      for (int k = 0; k < NUM_IRQ_OUTS; k++) begin
        if (out_idx == 3'(k)) begin
          case (reg_addr[1:0])
            PIO_IRQ_OFF_INTE: rd_val[RAW_W-1:0] = inte_a[k];
            PIO_IRQ_OFF_INTF: rd_val[RAW_W-1:0] = intf_a[k];
            PIO_IRQ_OFF_INTS: rd_val[RAW_W-1:0] = ints_a[k];
            default:          rd_val = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Directed, table-driven bench for pio_irq_ctrl with default parameters.
module tb_pio_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] sm_set, sm_clr;
  logic [3:0]  tx_full, rx_empty;
  logic [7:0]  flags, flags_prev;
  logic        reg_wr, reg_rd;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_rvalid;
  logic [1:0]  irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] set;
    logic [31:0] clr;
    logic [7:0]  exp;
  } flag_vec_t;

  flag_vec_t tbl [9];

  pio_irq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sm_set     (sm_set),
    .sm_clr     (sm_clr),
    .tx_full    (tx_full),
    .rx_empty   (rx_empty),
    .flags      (flags),
    .flags_prev (flags_prev),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic irq_settle;
`ifdef PIO_IRQ_REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    reg_rd   = 1'b1;
    reg_addr = a;
    tick();
    reg_rd   = 1'b0;
    chk({nm, "_rvalid"}, 32'(reg_rvalid), 32'd1);
    chk(nm, reg_rdata, exp);
  endtask

  initial begin
    logic [7:0] prev;

    tbl[0] = '{set: 32'h0008_0000, clr: 32'h0000_0000, exp: 8'h08};
    tbl[1] = '{set: 32'h0000_0001, clr: 32'h0100_0000, exp: 8'h09};
    tbl[2] = '{set: 32'h0000_0000, clr: 32'h0000_0800, exp: 8'h01};
    tbl[3] = '{set: 32'h0000_0002, clr: 32'h0200_0000, exp: 8'h03};
    tbl[4] = '{set: 32'h0000_0002, clr: 32'h0200_0000, exp: 8'h01};
    tbl[5] = '{set: 32'h8000_0000, clr: 32'h0000_0001, exp: 8'h80};
    tbl[6] = '{set: 32'h0000_FF00, clr: 32'h0000_0000, exp: 8'hFF};
    tbl[7] = '{set: 32'hFF00_0000, clr: 32'hFFFF_FFFF, exp: 8'h00};
    tbl[8] = '{set: 32'h0000_0000, clr: 32'h0000_0000, exp: 8'h00};

    reset_n = 1'b0; sm_set = '0; sm_clr = '0; tx_full = '0; rx_empty = '0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_flags_prev", 32'(flags_prev), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(reg_rvalid), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    rd(5'h00, 32'h0, "rst_rd_irq");
    rd(5'h02, 32'h0, "rst_rd_intr");
    rd(5'h04, 32'h0, "rst_rd_inte0");
    rd(5'h05, 32'h0, "rst_rd_intf0");
    rd(5'h06, 32'h0, "rst_rd_ints0");
    chk("rvalid_pulse", 32'(reg_rvalid), 32'h1);
    tick();
    chk("rvalid_drop", 32'(reg_rvalid), 32'h0);

    prev = 8'h00;
    for (int i = 0; i < 9; i++) begin
      sm_set = tbl[i].set;
      sm_clr = tbl[i].clr;
      tick();
      sm_set = '0;
      sm_clr = '0;
      chk($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_prev", i), 32'(flags_prev), 32'(prev));
      prev = tbl[i].exp;
    end

    sm_set = 32'h0008_0000;
    tick();
    sm_set = '0;
    chk("set_m2b3", 32'(flags), 32'h08);
    tick();
    chk("set_m2b3_prev", 32'(flags_prev), 32'h08);
    wr(5'h00, 32'h0000_0008);
    chk("hclr_lat1", 32'(flags), 32'h08);
    tick();
    chk("hclr_lat2", 32'(flags), 32'h00);

    wr(5'h01, 32'h0000_0105);
    chk("force_lat1", 32'(flags), 32'h00);
    tick();
    chk("force_lat2", 32'(flags), 32'h05);
    tick();
    chk("force_single", 32'(flags), 32'h05);
    rd(5'h01, 32'h0, "rd_force");
    rd(5'h00, 32'h05, "rd_irq_flags");
    rd(5'h02, 32'h500, "rd_intr_flags");
    wr(5'h00, 32'h0000_0005);
    tick();
    chk("hclr_force", 32'(flags), 32'h00);

    tx_full  = 4'b0100;
    rx_empty = 4'b0011;
    rd(5'h02, 32'h043, "rd_intr_fifo");
    wr(5'h04, 32'h040);
    irq_settle();
    chk("irq0_en", 32'(irq[0]), 32'h1);
    chk("irq1_idle", 32'(irq[1]), 32'h0);
    rd(5'h06, 32'h040, "rd_ints0");
    rd(5'h04, 32'h040, "rd_inte0");
    tx_full = 4'b0000;
    irq_settle();
    chk("irq0_src_off", 32'(irq[0]), 32'h0);
    rx_empty = 4'b0000;

    wr(5'h09, 32'h001);
    irq_settle();
    chk("irq1_force", 32'(irq[1]), 32'h1);
    chk("irq0_indep", 32'(irq[0]), 32'h0);
    rd(5'h0A, 32'h001, "rd_ints1");
    wr(5'h09, 32'h000);
    irq_settle();
    chk("irq1_unforce", 32'(irq[1]), 32'h0);

    wr(5'h04, 32'h0);
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 5'h04; reg_wdata = 32'hFF;
    tick();
    reg_rd = 1'b0; reg_wr = 1'b0;
    chk("rdwr_rvalid", 32'(reg_rvalid), 32'h1);
    chk("rdwr_old", reg_rdata, 32'h0);
    tick();
    chk("rdwr_rvalid_once", 32'(reg_rvalid), 32'h0);
    chk("rdata_hold", reg_rdata, 32'h0);
    rd(5'h04, 32'h0FF, "rdwr_new");

    wr(5'h04, 32'hFFFF_FFFF);
    rd(5'h04, 32'hFFF, "inte_mask_w");
    wr(5'h04, 32'h0);
    wr(5'h0C, 32'hFFF);
    rd(5'h0C, 32'h0, "rd_out2_inte");
    rd(5'h03, 32'h0, "rd_unmapped3");
    rd(5'h0E, 32'h0, "rd_out2_ints");

    rx_empty = 4'b1001;
    wr(5'h04, 32'h0FF);
    reg_rd = 1'b1; reg_addr = 5'h04;
    tick();
    chk("b2b_0", reg_rdata, 32'h0FF);
    reg_addr = 5'h02;
    tick();
    reg_rd = 1'b0;
    chk("b2b_1", reg_rdata, 32'h009);
    chk("b2b_1_rvalid", 32'(reg_rvalid), 32'h1);
    wr(5'h04, 32'h0);
    rx_empty = 4'b0000;

    wr(5'h05, 32'h001);
    irq_settle();
    chk("pre_rst_irq0", 32'(irq[0]), 32'h1);
    wr(5'h01, 32'h80);
    reset_n = 1'b0;
    #1;
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_flags", 32'(flags), 32'h0);
    #2;
    reset_n = 1'b1;
    tick(); tick();
    chk("midrst_strobe_gone", 32'(flags), 32'h0);
    rd(5'h05, 32'h0, "midrst_intf0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
